// File: rtl/mult_div_seq.sv
// Sequential signed multiply/divide engine with its sequencing FSM.
// Booth radix-2 multiply and restoring divide, one step per clock, results land in HI/LO.
module mult_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             write_hi,
  output logic             write_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned AccW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StIter, StDone} stateT;

  stateT            stateQ, stateD;
  logic             isDivQ, isDivD;
  logic             divZeroQ, divZeroD;
  logic             negQuoQ, negQuoD;
  logic             negRemQ, negRemD;
  logic [CntW-1:0]  countQ, countD;
  logic [AccW-1:0]  accQ, accD;
  logic [WIDTH-1:0] operandQ, operandD;
  logic [WIDTH-1:0] remQ, remD;
  logic [WIDTH-1:0] quoQ, quoD;
  logic [WIDTH-1:0] hiQ, hiD;
  logic [WIDTH-1:0] loQ, loD;

  // Booth step: partial product is widened by one bit so that subtracting the most
  // negative multiplicand cannot corrupt the sign used by the arithmetic shift.
  logic [WIDTH:0] partialExt;
  logic [WIDTH:0] mcandExt;
  logic [WIDTH:0] boothSum;

  always_comb begin
    partialExt = {accQ[AccW-1], accQ[AccW-1:WIDTH+1]};
    mcandExt   = {operandQ[WIDTH-1], operandQ};
    case (accQ[1:0])
      2'b01:   boothSum = partialExt + mcandExt;
      2'b10:   boothSum = partialExt - mcandExt;
      default: boothSum = partialExt;
    endcase
  end

  // Restoring divide step on magnitudes; quotient bits shift in from the right.
  logic [WIDTH:0]   divShifted;
  logic [WIDTH-1:0] divDiff;
  logic             divFits;

  always_comb begin
    divShifted = {remQ, quoQ[WIDTH-1]};
    divFits    = divShifted >= {1'b0, operandQ};
    divDiff    = divShifted[WIDTH-1:0] - operandQ;
  end

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;

  always_comb begin
    absA = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    absB = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
  end

  always_comb begin
    stateD   = stateQ;
    isDivD   = isDivQ;
    divZeroD = divZeroQ;
    negQuoD  = negQuoQ;
    negRemD  = negRemQ;
    countD   = countQ;
    accD     = accQ;
    operandD = operandQ;
    remD     = remQ;
    quoD     = quoQ;
    hiD      = hiQ;
    loD      = loQ;

    unique case (stateQ)
      StIdle: begin
        if (start_mult) begin
          stateD   = StIter;
          isDivD   = 1'b0;
          divZeroD = 1'b0;
          countD   = '0;
          accD     = {{WIDTH{1'b0}}, op_b, 1'b0};
          operandD = op_a;
        end else if (start_div) begin
          if (op_b == '0) begin
            stateD   = StDone;
            divZeroD = 1'b1;
          end else begin
            stateD   = StIter;
            isDivD   = 1'b1;
            divZeroD = 1'b0;
            countD   = '0;
            remD     = '0;
            quoD     = absA;
            operandD = absB;
            negQuoD  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            negRemD  = op_a[WIDTH-1];
          end
        end
      end

      StIter: begin
        if (countQ == CntW'(WIDTH)) begin
          stateD = StDone;
          if (isDivQ) begin
            hiD = negRemQ ? (~remQ + 1'b1) : remQ;
            loD = negQuoQ ? (~quoQ + 1'b1) : quoQ;
          end else begin
            hiD = accQ[AccW-1:WIDTH+1];
            loD = accQ[WIDTH:1];
          end
        end else begin
          countD = countQ + 1'b1;
          if (isDivQ) begin
            if (divFits) begin
              remD = divDiff;
              quoD = {quoQ[WIDTH-2:0], 1'b1};
            end else begin
              remD = divShifted[WIDTH-1:0];
              quoD = {quoQ[WIDTH-2:0], 1'b0};
            end
          end else begin
            accD = {boothSum, accQ[WIDTH:1]};
          end
        end
      end

      StDone: begin
        stateD = StIdle;
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ   <= StIdle;
      isDivQ   <= 1'b0;
      divZeroQ <= 1'b0;
      negQuoQ  <= 1'b0;
      negRemQ  <= 1'b0;
      countQ   <= '0;
      accQ     <= '0;
      operandQ <= '0;
      remQ     <= '0;
      quoQ     <= '0;
      hiQ      <= '0;
      loQ      <= '0;
    end else begin
      stateQ   <= stateD;
      isDivQ   <= isDivD;
      divZeroQ <= divZeroD;
      negQuoQ  <= negQuoD;
      negRemQ  <= negRemD;
      countQ   <= countD;
      accQ     <= accD;
      operandQ <= operandD;
      remQ     <= remD;
      quoQ     <= quoD;
      hiQ      <= hiD;
      loQ      <= loD;
    end
  end

  always_comb begin
    busy     = stateQ != StIdle;
    done     = stateQ == StDone;
    div_zero = (stateQ == StDone) && divZeroQ;
    write_hi = (stateQ == StDone) && !divZeroQ;
    write_lo = (stateQ == StDone) && !divZeroQ;
    hi_out   = hiQ;
    lo_out   = loQ;
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: hand-computed products, quotients, timing and reset cases.
module tb_mult_div_seq;

  logic        clock;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        write_hi;
  logic        write_lo;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int compared;
  int mismatched;

  mult_div_seq #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .write_hi   (write_hi),
    .write_lo   (write_lo),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a one-cycle start; returns at the falling edge just after the sampling edge.
  task automatic startOp(input bit mult, input bit div, input logic [31:0] a,
                         input logic [31:0] b);
    @(negedge clock);
    start_mult = mult;
    start_div  = div;
    op_a       = a;
    op_b       = b;
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  // Counts rising edges until done is seen, with a bound; busy must hold throughout.
  task automatic waitDone(output int edges, output bit allBusy);
    edges   = 0;
    allBusy = busy;
    while (!done && edges < 100) begin
      @(negedge clock);
      edges++;
      if (!busy) allBusy = 1'b0;
    end
  endtask

  int n;
  bit allBusy;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    repeat (2) @(negedge clock);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi_out, lo_out}, 64'd0);
    reset = 1'b1;

    // 7 * -3
    startOp(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    waitDone(n, allBusy);
    check("m1_latency", 64'(n), 64'd33);
    check("m1_busy", 64'(allBusy), 64'd1);
    check("m1_writes", {62'd0, write_hi, write_lo}, 64'd3);
    check("m1_divzero", 64'(div_zero), 64'd0);
    check("m1_result", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge clock);
    check("m1_idle", {62'd0, busy, done}, 64'd0);

    // -2^31 * -2^31
    startOp(1'b1, 1'b0, 32'h80000000, 32'h80000000);
    waitDone(n, allBusy);
    check("m2_result", {hi_out, lo_out}, 64'h40000000_00000000);

    // -7 / 2 and 7 / -2
    startOp(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    waitDone(n, allBusy);
    check("d1_latency", 64'(n), 64'd33);
    check("d1_result", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFFD);
    startOp(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE);
    waitDone(n, allBusy);
    check("d2_result", {hi_out, lo_out}, 64'h00000001_FFFFFFFD);

    // 5 / 0: immediate done, outputs untouched
    startOp(1'b0, 1'b1, 32'd5, 32'd0);
    check("dz_done", {62'd0, done, div_zero}, 64'd3);
    check("dz_writes", {62'd0, write_hi, write_lo}, 64'd0);
    check("dz_hold", {hi_out, lo_out}, 64'h00000001_FFFFFFFD);
    @(negedge clock);
    check("dz_idle", {62'd0, busy, done}, 64'd0);

    // -2^31 / -1
    startOp(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    waitDone(n, allBusy);
    check("d3_result", {hi_out, lo_out}, 64'h00000000_80000000);
    check("d3_divzero", 64'(div_zero), 64'd0);

    // 12345 * -100 with a divide-by-zero start and operand changes mid-run
    startOp(1'b1, 1'b0, 32'd12345, 32'hFFFFFF9C);
    repeat (9) @(negedge clock);
    start_div = 1'b1;
    op_a      = 32'd99;
    op_b      = 32'd0;
    @(negedge clock);
    start_div = 1'b0;
    check("ign_nodone", 64'(done), 64'd0);
    waitDone(n, allBusy);
    check("ign_latency", 64'(n + 10), 64'd33);
    check("ign_result", {hi_out, lo_out}, 64'hFFFFFFFF_FFED29BC);
    check("ign_divzero", 64'(div_zero), 64'd0);

    // Both starts: -6 * 5, not -6 / 5
    startOp(1'b1, 1'b1, 32'hFFFFFFFA, 32'd5);
    waitDone(n, allBusy);
    check("both_latency", 64'(n), 64'd33);
    check("both_result", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFE2);

    // Asynchronous reset in the middle of a multiply
    startOp(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (19) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    waitDone(n, allBusy);
    check("rst_nodone", 64'(n), 64'd100);

    // Engine recovers after reset
    startOp(1'b1, 1'b0, 32'd3, 32'd4);
    waitDone(n, allBusy);
    check("rec_result", {hi_out, lo_out}, 64'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
